virtio_notify_dma_master: RTL and testbench

// - Virtio queue-notify service engine between the CSR block and the DMA AXI fabric.
// - After reset, issues one AXI4-Lite init write to the CSR.
// - Records per-queue doorbell (notify) pulses as pending bits.
// - Round-robin services pending queues: one AXI4-Lite read of each queue's avail index.
// - Reports the new-descriptor count to the DMA side.

---
 rtl/virtio_dma_pkg.sv | 20 ++
 rtl/virtio_rr_pick.sv | 28 ++
 rtl/virtio_notify_dma_master.sv | 238 +++++++++++++++++++++++
 tb/tb_virtio_notify_dma_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/virtio_dma_pkg.sv
// Shared types and constants for the virtio notify / DMA master engine.
package virtio_dma_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_B,
        ST_IDLE,
        ST_AR,
        ST_R
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int unsigned QIDX_W = 2;
    typedef logic [QIDX_W-1:0] qidx_t;

    localparam logic [31:0] AVAIL_BASE_DEF   = 32'h0001_0000;
    localparam logic [31:0] AVAIL_STRIDE_DEF = 32'h0000_1000;

endpackage

// File: rtl/virtio_rr_pick.sv
// Round-robin first-set finder: returns the first pending queue at or after ptr,
// wrapping modulo NUM_Q.
module virtio_rr_pick
    import virtio_dma_pkg::*;
#(
    parameter int unsigned NUM_Q = 3
) (
    input  logic [NUM_Q-1:0] pending,
    input  qidx_t            ptr,
    output qidx_t            idx,
    output logic             any
);

    // Walk offsets from farthest to nearest so the offset closest to ptr wins.
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_Q) - 1; i >= 0; i--) begin
            for (int j = 0; j < int'(NUM_Q); j++) begin
                if (pending[j] && (j == ((int'(ptr) + i) % int'(NUM_Q)))) begin
                    idx = qidx_t'(j);
                end
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/virtio_notify_dma_master.sv
// Virtio queue-notify engine: one AXI-Lite init write to the CSR, then
// round-robin avail-index reads of doorbelled queues with new-descriptor reporting.
module virtio_notify_dma_master
    import virtio_dma_pkg::*;
#(
    parameter int unsigned       NUM_Q        = 3,
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] INIT_ADDR    = 32'h0000_0014,
    parameter logic [DATA_W-1:0] INIT_DATA    = 32'h0000_000F,
    parameter logic [ADDR_W-1:0] AVAIL_BASE   = AVAIL_BASE_DEF,
    parameter logic [ADDR_W-1:0] AVAIL_STRIDE = AVAIL_STRIDE_DEF
) (
    input  logic                  clk,
    input  logic                  csr_rst_n,
    input  logic [NUM_Q-1:0]      queue_notify_set,
    input  logic [NUM_Q-1:0]      queue_notify_clr,
    output logic [NUM_Q-1:0]      queue_pending,
    output logic                  init_done,
    output logic                  init_err,
    output logic                  work_valid,
    output logic [1:0]            work_q,
    output logic [15:0]           work_cnt,
    output logic                  rd_err,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    state_t              state_q, state_d;
    logic [NUM_Q-1:0]    pending_q, pending_d, svc_clr;
    logic [15:0]         last_idx_q [NUM_Q];
    logic [15:0]         last_idx_d [NUM_Q];
    qidx_t               ptr_q, ptr_d, sel_q, sel_d, pick_idx;
    logic                pick_any;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                init_done_q, init_done_d, init_err_q, init_err_d;
    logic                work_valid_q, work_valid_d, rd_err_q, rd_err_d;
    qidx_t               work_q_q, work_q_d;
    logic [15:0]         work_cnt_q, work_cnt_d;
    logic [15:0]         new_idx;
    logic                rdata_hi_unused;

    assign new_idx         = m_rdata[15:0];
    assign rdata_hi_unused = ^m_rdata[DATA_W-1:16];

    virtio_rr_pick #(.NUM_Q(NUM_Q)) u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        last_idx_d   = last_idx_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        init_done_d  = init_done_q;
        init_err_d   = init_err_q;
        work_valid_d = 1'b0;
        rd_err_d     = 1'b0;
        work_q_d     = work_q_q;
        work_cnt_d   = work_cnt_q;
        svc_clr      = '0;

        unique case (state_q)
            ST_INIT: begin
                // Nothing launched yet: raise AW and W together on the first cycle out of reset.
                if (!awvalid_q && !wvalid_q && !aw_done_q && !w_done_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = INIT_ADDR;
                    wdata_d   = INIT_DATA;
                    wstrb_d   = '1;
                end else begin
                    if (awvalid_q && m_awready) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                    if (wvalid_q && m_wready) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        bready_d = 1'b1;
                        state_d  = ST_INIT_B;
                    end
                end
            end
            ST_INIT_B: begin
                if (m_bvalid) begin
                    bready_d    = 1'b0;
                    init_done_d = 1'b1;
                    init_err_d  = (m_bresp != AXI_RESP_OKAY);
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d     = pick_idx;
                    araddr_d  = AVAIL_BASE + ADDR_W'(pick_idx) * AVAIL_STRIDE;
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    ptr_d    = (sel_q == QIDX_W'(NUM_Q - 1)) ? '0 : sel_q + qidx_t'(1);
                    state_d  = ST_IDLE;
                    if (m_rresp == AXI_RESP_OKAY) begin
                        svc_clr[sel_q] = 1'b1;
                        if (new_idx != last_idx_q[sel_q]) begin
                            work_valid_d      = 1'b1;
                            work_q_d          = sel_q;
                            work_cnt_d        = new_idx - last_idx_q[sel_q];
                            last_idx_d[sel_q] = new_idx;
                        end
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A doorbell in the same cycle beats both a cancel and a service completion.
        for (int i = 0; i < int'(NUM_Q); i++) begin
            pending_d[i] = queue_notify_set[i] | (pending_q[i] & ~(queue_notify_clr[i] | svc_clr[i]));
        end
    end

    always_ff @(posedge clk or negedge csr_rst_n) begin
        if (!csr_rst_n) begin
            state_q      <= ST_INIT;
            pending_q    <= '0;
            last_idx_q   <= '{default: '0};
            ptr_q        <= '0;
            sel_q        <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            init_done_q  <= 1'b0;
            init_err_q   <= 1'b0;
            work_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            work_q_q     <= '0;
            work_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_idx_q   <= last_idx_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            init_done_q  <= init_done_d;
            init_err_q   <= init_err_d;
            work_valid_q <= work_valid_d;
            rd_err_q     <= rd_err_d;
            work_q_q     <= work_q_d;
            work_cnt_q   <= work_cnt_d;
        end
    end

    assign queue_pending = pending_q;
    assign init_done     = init_done_q;
    assign init_err      = init_err_q;
    assign work_valid    = work_valid_q;
    assign work_q        = work_q_q;
    assign work_cnt      = work_cnt_q;
    assign rd_err        = rd_err_q;
    assign m_awaddr      = awaddr_q;
    assign m_awvalid     = awvalid_q;
    assign m_wdata       = wdata_q;
    assign m_wstrb       = wstrb_q;
    assign m_wvalid      = wvalid_q;
    assign m_bready      = bready_q;
    assign m_araddr      = araddr_q;
    assign m_arvalid     = arvalid_q;
    assign m_rready      = rready_q;

endmodule

// File: tb/tb_virtio_notify_dma_master.sv
// Directed bench for virtio_notify_dma_master: an in-bench AXI-Lite slave plus a
// scoreboard of expected read outcomes built from a per-queue last-index model.
module tb_virtio_notify_dma_master;

    localparam int NUM_Q = 3;

    logic              clk = 1'b0;
    logic              csr_rst_n = 1'b0;
    logic [NUM_Q-1:0]  queue_notify_set = '0;
    logic [NUM_Q-1:0]  queue_notify_clr = '0;
    logic [NUM_Q-1:0]  queue_pending;
    logic              init_done, init_err, work_valid, rd_err;
    logic [1:0]        work_q;
    logic [15:0]       work_cnt;
    logic [31:0]       m_awaddr, m_wdata, m_araddr;
    logic [31:0]       m_rdata = '0;
    logic [3:0]        m_wstrb;
    logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic              m_awready = 1'b1, m_wready = 1'b1, m_bvalid = 1'b0;
    logic              m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]        m_bresp = '0, m_rresp = '0;

    typedef struct {
        int          q;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        bit          clr_mid;
        bit          exp_work;
        logic [15:0] exp_cnt;
        bit          exp_rderr;
        bit          exp_pend;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [15:0] model_last [NUM_Q];
    int          errors = 0;
    int          checks = 0;

    virtio_notify_dma_master dut (
        .clk              (clk),
        .csr_rst_n        (csr_rst_n),
        .queue_notify_set (queue_notify_set),
        .queue_notify_clr (queue_notify_clr),
        .queue_pending    (queue_pending),
        .init_done        (init_done),
        .init_err         (init_err),
        .work_valid       (work_valid),
        .work_q           (work_q),
        .work_cnt         (work_cnt),
        .rd_err           (rd_err),
        .m_awaddr         (m_awaddr),
        .m_awvalid        (m_awvalid),
        .m_awready        (m_awready),
        .m_wdata          (m_wdata),
        .m_wstrb          (m_wstrb),
        .m_wvalid         (m_wvalid),
        .m_wready         (m_wready),
        .m_bresp          (m_bresp),
        .m_bvalid         (m_bvalid),
        .m_bready         (m_bready),
        .m_araddr         (m_araddr),
        .m_arvalid        (m_arvalid),
        .m_arready        (m_arready),
        .m_rdata          (m_rdata),
        .m_rresp          (m_rresp),
        .m_rvalid         (m_rvalid),
        .m_rready         (m_rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_Q-1:0] set_mask, input logic [NUM_Q-1:0] clr_mask);
        queue_notify_set = set_mask;
        queue_notify_clr = clr_mask;
        @(negedge clk);
        queue_notify_set = '0;
        queue_notify_clr = '0;
        checkOutput("pending_set", queue_pending & set_mask, set_mask);
    endtask

    // Expected outcome of one avail-index read, derived from the bench's own last-index model.
    task automatic pushRead(input int q, input logic [15:0] rdata, input logic [1:0] rresp, input bit clr_mid);
        rd_exp_t e;
        e.q         = q;
        e.addr      = 32'h0001_0000 + 32'(q) * 32'h0000_1000;
        e.rdata     = {16'hA5A5, rdata};
        e.rresp     = rresp;
        e.clr_mid   = clr_mid;
        e.exp_work  = 1'b0;
        e.exp_cnt   = '0;
        e.exp_rderr = (rresp != 2'b00);
        e.exp_pend  = (rresp != 2'b00);
        if (rresp == 2'b00 && rdata != model_last[q]) begin
            e.exp_work    = 1'b1;
            e.exp_cnt     = rdata - model_last[q];
            model_last[q] = rdata;
        end
        sb.push_back(e);
    endtask

    task automatic serviceRead();
        rd_exp_t e;
        int      n;
        e = sb.pop_front();
        n = 0;
        while (m_arvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("arvalid_rise", m_arvalid, 1);
        checkOutput("araddr", m_araddr, e.addr);
        if (e.clr_mid) queue_notify_clr = NUM_Q'(1 << e.q);
        @(negedge clk);
        queue_notify_clr = '0;
        checkOutput("arvalid_hold", m_arvalid, 1);
        checkOutput("araddr_hold", m_araddr, e.addr);
        if (e.clr_mid) checkOutput("clr_in_flight", queue_pending[e.q], 0);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        checkOutput("rready", m_rready, 1);
        checkOutput("arvalid_drop", m_arvalid, 0);
        m_rvalid = 1'b1;
        m_rdata  = e.rdata;
        m_rresp  = e.rresp;
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rresp  = '0;
        checkOutput("work_valid", work_valid, e.exp_work);
        checkOutput("rd_err", rd_err, e.exp_rderr);
        if (e.exp_work) begin
            checkOutput("work_q", work_q, e.q);
            checkOutput("work_cnt", work_cnt, e.exp_cnt);
        end
        checkOutput("pending_after", queue_pending[e.q], e.exp_pend);
        @(negedge clk);
        checkOutput("pulse_end", {work_valid, rd_err, m_rready}, 0);
    endtask

    task automatic doInit(input logic [1:0] bresp, input logic [NUM_Q-1:0] early_set);
        csr_rst_n        = 1'b0;
        queue_notify_set = '0;
        queue_notify_clr = '0;
        m_awready        = 1'b1;
        m_wready         = 1'b1;
        m_bvalid         = 1'b0;
        m_arready        = 1'b0;
        m_rvalid         = 1'b0;
        model_last       = '{default: '0};
        sb.delete();
        repeat (2) @(negedge clk);
        checkOutput("rst_pending", queue_pending, 0);
        checkOutput("rst_flags", {init_done, init_err, work_valid, rd_err}, 0);
        checkOutput("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        checkOutput("rst_awaddr", m_awaddr, 0);
        checkOutput("rst_araddr", m_araddr, 0);
        csr_rst_n        = 1'b1;
        queue_notify_set = early_set;
        @(negedge clk);
        queue_notify_set = '0;
        checkOutput("init_aw_w", {m_awvalid, m_wvalid}, 2'b11);
        checkOutput("init_awaddr", m_awaddr, 32'h0000_0014);
        checkOutput("init_wdata", m_wdata, 32'h0000_000F);
        checkOutput("init_wstrb", m_wstrb, 4'hF);
        @(negedge clk);
        checkOutput("init_aw_w_drop", {m_awvalid, m_wvalid}, 0);
        checkOutput("init_bready", m_bready, 1);
        m_bvalid = 1'b1;
        m_bresp  = bresp;
        @(negedge clk);
        m_bvalid = 1'b0;
        m_bresp  = '0;
        checkOutput("init_done", init_done, 1);
        checkOutput("init_err", init_err, (bresp != 2'b00));
        checkOutput("bready_drop", m_bready, 0);
        checkOutput("no_early_read", m_arvalid, 0);
        checkOutput("early_pending", queue_pending, early_set);
    endtask

    initial begin
        $display("[TB] starting virtio_notify_dma_master bench");

        doInit(2'b00, '0);
        applyStimulus(3'b001, 3'b000);
        pushRead(0, 16'd5, 2'b00, 1'b0);
        serviceRead();
        applyStimulus(3'b001, 3'b000);
        pushRead(0, 16'd5, 2'b00, 1'b0);
        serviceRead();

        // Set and cancel in the same cycle: the doorbell must survive.
        applyStimulus(3'b010, 3'b010);
        pushRead(1, 16'hFFFE, 2'b00, 1'b0);
        serviceRead();
        applyStimulus(3'b010, 3'b000);
        pushRead(1, 16'h0003, 2'b00, 1'b1);
        serviceRead();

        applyStimulus(3'b100, 3'b000);
        pushRead(2, 16'd9, 2'b10, 1'b0);
        pushRead(2, 16'd9, 2'b00, 1'b0);
        serviceRead();
        serviceRead();
        checkOutput("init_sticky", {init_done, init_err, m_awvalid, m_wvalid}, 4'b1000);

        doInit(2'b10, 3'b101);
        pushRead(0, 16'd5, 2'b00, 1'b0);
        pushRead(2, 16'd7, 2'b00, 1'b0);
        serviceRead();
        serviceRead();
        checkOutput("init_err_sticky", {init_done, init_err}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
